// File: rtl/one_unit_pkg.sv
// Shared constants, state encoding and element indexing for the one-unit FastICA datapath.
package one_unit_pkg;

  localparam int W     = 26;
  localparam int FRAC  = 13;
  localparam int NMAT  = 4;
  localparam int NEL   = NMAT * 16;
  localparam int ACC_W = 2 * W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Flat element index of (m,i,j) inside a packed matrix bank.
  function automatic logic [5:0] idx(input logic [1:0] m, input logic [1:0] i, input logic [1:0] j);
    return {m, i, j};
  endfunction

endpackage

// File: rtl/one_unit_mac.sv
// Signed W x W multiply-accumulate with clear-on-first and fixed-point output scaling.
// ONE_UNIT_MUL3_SAT_EN selects saturating output instead of wrap-around truncation.
module one_unit_mac
  import one_unit_pkg::*;
(
  input  logic                clk_mul,
  input  logic                rst_mul_n,
  input  logic                clr,
  input  logic                en,
  input  logic                first,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] res,
  output logic                sat
);

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_q;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W - 2*W){prod[2*W-1]}}, prod};
  assign sum      = first ? prod_ext : acc_q + prod_ext;

  always_ff @(posedge clk_mul or negedge rst_mul_n) begin
    if (!rst_mul_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum;
    end
  end

`ifdef ONE_UNIT_MUL3_SAT_EN
  // Overflow whenever the bits above the kept window are not a pure sign extension.
  logic ovf;
  assign ovf = !((&sum[ACC_W-1:W+FRAC-1]) | ~(|sum[ACC_W-1:W+FRAC-1]));

  always_comb begin
    res = sum[W+FRAC-1:FRAC];
    sat = ovf;
    if (ovf) begin
      res = sum[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign res = sum[W+FRAC-1:FRAC];
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/one_unit_mul3.sv
// Cube stage: C_m = A_m * B_m over four 4x4 matrices using one shared MAC, FSM-sequenced.
// Build option ONE_UNIT_MUL3_SAT_EN enables saturating result writes and sat_flag reporting.
module one_unit_mul3
  import one_unit_pkg::*;
(
  input  logic              clk_mul,
  input  logic              rst_mul_n,
  input  logic              start,
  input  logic              en_mul,
  input  logic [NEL*W-1:0]  a_bus,
  input  logic [NEL*W-1:0]  b_bus,
  input  logic [4*W-1:0]    zi_bus,
  output logic              ready,
  output logic              done,
  output logic [NEL*W-1:0]  c_bus,
  output logic [4*W-1:0]    zo_bus,
  output logic [NEL*W-1:0]  zw_bus,
  output logic              sat_flag
);

  state_t state_q, state_d;

  logic [7:0]          cnt_q;
  logic [1:0]          m_c, i_c, j_c, k_c;
  logic [W-1:0]        a_in [NEL];
  logic [W-1:0]        b_in [NEL];
  logic [W-1:0]        a_q  [NEL];
  logic [W-1:0]        b_q  [NEL];
  logic [W-1:0]        c_q  [NEL];
  logic [4*W-1:0]      zo_q;
  logic                sat_q;
  logic                accept;
  logic                mac_en;
  logic                mac_sat;
  logic signed [W-1:0] mac_res;

  // Counter fields: k innermost, then j, i, m.
  assign {m_c, i_c, j_c, k_c} = cnt_q;
  assign accept   = ready & start;
  assign mac_en   = (state_q == MAC);
  assign zo_bus   = zo_q;
  assign sat_flag = sat_q;

  generate
    for (genvar gi = 0; gi < NEL; gi++) begin : g_bank
      assign a_in[gi]             = a_bus[gi*W +: W];
      assign b_in[gi]             = b_bus[gi*W +: W];
      assign c_bus[gi*W +: W]     = c_q[gi];
      assign zw_bus[gi*W +: W]    = b_q[gi];
    end
  endgenerate

  always_ff @(posedge clk_mul or negedge rst_mul_n) begin
    if (!rst_mul_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = en_mul ? MAC : DONE;
      MAC:     if (cnt_q == 8'hFF) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
    done  = (state_q == DONE);
  end

  // The latched zTw bank doubles as the B operand and the forwarded zw_bus.
  always_ff @(posedge clk_mul or negedge rst_mul_n) begin
    if (!rst_mul_n) begin
      cnt_q <= '0;
      zo_q  <= '0;
      sat_q <= 1'b0;
      for (int n = 0; n < NEL; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
    end else if (accept) begin
      cnt_q <= '0;
      zo_q  <= zi_bus;
      sat_q <= 1'b0;
      for (int n = 0; n < NEL; n++) begin
        a_q[n] <= a_in[n];
        b_q[n] <= b_in[n];
        if (!en_mul) c_q[n] <= a_in[n];
      end
    end else if (mac_en) begin
      cnt_q <= cnt_q + 8'd1;
      if (k_c == 2'd3) begin
        c_q[idx(m_c, i_c, j_c)] <= mac_res;
        sat_q                   <= sat_q | mac_sat;
      end
    end
  end

  one_unit_mac u_mac (
    .clk_mul   (clk_mul),
    .rst_mul_n (rst_mul_n),
    .clr       (accept),
    .en        (mac_en),
    .first     (k_c == 2'd0),
    .a         (a_q[idx(m_c, i_c, k_c)]),
    .b         (b_q[idx(m_c, k_c, j_c)]),
    .res       (mac_res),
    .sat       (mac_sat)
  );

endmodule

// File: tb/tb_one_unit_mul3.sv
// Self-checking bench for one_unit_mul3: matrix-product model plus directed scenarios.
module tb_one_unit_mul3;
  import one_unit_pkg::*;

  localparam int  BW   = NEL * W;
  localparam longint MAXV = 33554431;
  localparam longint MINV = -33554432;

  logic            clk_mul = 1'b0;
  logic            rst_mul_n = 1'b0;
  logic            start = 1'b0;
  logic            en_mul = 1'b0;
  logic [BW-1:0]   a_bus = '0;
  logic [BW-1:0]   b_bus = '0;
  logic [4*W-1:0]  zi_bus = '0;
  logic            ready, done, sat_flag;
  logic [BW-1:0]   c_bus, zw_bus;
  logic [4*W-1:0]  zo_bus;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int a_v [NEL];
  int b_v [NEL];
  int exp_c [NEL];
  logic [BW-1:0]  exp_zw;
  logic [4*W-1:0] exp_zo;
  logic           exp_sat;

  one_unit_mul3 dut (
    .clk_mul   (clk_mul),
    .rst_mul_n (rst_mul_n),
    .start     (start),
    .en_mul    (en_mul),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .zi_bus    (zi_bus),
    .ready     (ready),
    .done      (done),
    .c_bus     (c_bus),
    .zo_bus    (zo_bus),
    .zw_bus    (zw_bus),
    .sat_flag  (sat_flag)
  );

  always #5 clk_mul = ~clk_mul;

  function automatic int elem(input logic [BW-1:0] bus, input int n);
    logic signed [W-1:0] e;
    e = bus[n*W +: W];
    return int'(e);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_ops();
    for (int n = 0; n < NEL; n++) begin
      a_bus[n*W +: W] = W'(a_v[n]);
      b_bus[n*W +: W] = W'(b_v[n]);
    end
  endtask

  // Plain matrix product per matrix, scaled by 2^-FRAC, then wrapped or clamped.
  task automatic model(input bit en);
    exp_sat = 1'b0;
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          longint s;
          longint q;
          logic signed [W-1:0] t;
          s = 0;
          for (int k = 0; k < 4; k++)
            s += longint'(a_v[m*16+i*4+k]) * longint'(b_v[m*16+k*4+j]);
          q = s >>> FRAC;
`ifdef ONE_UNIT_MUL3_SAT_EN
          if (q > MAXV) begin q = MAXV; exp_sat = 1'b1; end
          else if (q < MINV) begin q = MINV; exp_sat = 1'b1; end
`else
          t = q[W-1:0];
          q = longint'(t);
`endif
          exp_c[m*16+i*4+j] = en ? int'(q) : a_v[m*16+i*4+j];
        end
  endtask

  always @(negedge clk_mul) begin : cmp
    int bc, bz, bo;
    if (rst_mul_n && done) begin
      done_cnt++;
      bc = 0; bz = 0; bo = 0;
      for (int n = NEL-1; n >= 0; n--) begin
        if (elem(c_bus, n) != exp_c[n]) bc = n;
        if (elem(zw_bus, n) != elem(exp_zw, n)) bz = n;
      end
      for (int n = 3; n >= 0; n--)
        if (zo_bus[n*W +: W] != exp_zo[n*W +: W]) bo = n;
      chk($sformatf("c_bus[%0d]", bc), elem(c_bus, bc), exp_c[bc]);
      chk($sformatf("zw_bus[%0d]", bz), elem(zw_bus, bz), elem(exp_zw, bz));
      chk($sformatf("zo_bus[%0d]", bo), longint'(zo_bus[bo*W +: W]), longint'(exp_zo[bo*W +: W]));
      chk("sat_flag", sat_flag, exp_sat);
    end
  end

  task automatic do_op(input string tag, input bit en, input int exp_lat, input bit change_in,
                       input int pulse_at, input int rst_at);
    int lat;
    int d0;
    bit rdy_bad;
    load_ops();
    model(en);
    exp_zo = zi_bus;
    exp_zw = b_bus;
    d0 = done_cnt;
    rdy_bad = 1'b0;
    @(negedge clk_mul);
    chk({tag, " ready before accept"}, ready, 1);
    start = 1'b1;
    en_mul = en;
    @(posedge clk_mul);
    #1 start = 1'b0;
    lat = 0;
    if (change_in) begin
      zi_bus = ~zi_bus;
      b_bus  = ~b_bus;
      a_bus  = ~a_bus;
    end
    while (!done && lat < 400 && !(rst_at >= 0 && lat == rst_at)) begin
      if (ready) rdy_bad = 1'b1;
      start = (lat == pulse_at);
      @(posedge clk_mul);
      #1 lat++;
    end
    start = 1'b0;
    chk({tag, " ready high while busy"}, rdy_bad, 0);
    if (rst_at >= 0) begin
      rst_mul_n = 1'b0;
      #1;
      chk({tag, " c_bus cleared"}, (c_bus == '0), 1);
      chk({tag, " zo_bus cleared"}, (zo_bus == '0), 1);
      chk({tag, " zw_bus cleared"}, (zw_bus == '0), 1);
      chk({tag, " done in reset"}, done, 0);
      repeat (3) @(posedge clk_mul);
      @(negedge clk_mul) rst_mul_n = 1'b1;
      repeat (20) @(posedge clk_mul);
      #1;
      chk({tag, " done pulses after abort"}, done_cnt - d0, 0);
      chk({tag, " ready after abort"}, ready, 1);
    end else begin
      chk({tag, " latency"}, lat, exp_lat);
      @(posedge clk_mul);
      #1;
      chk({tag, " done is one cycle"}, done, 0);
      chk({tag, " ready after done"}, ready, 1);
      repeat (4) @(posedge clk_mul);
      #1;
      chk({tag, " done count"}, done_cnt - d0, 1);
    end
  endtask

  task automatic setup_t1();
    for (int n = 0; n < NEL; n++) begin
      a_v[n] = ((n % 16) / 4 == n % 4) ? 8192 : 0;
      b_v[n] = n * 100;
    end
    zi_bus = {26'd11, 26'd22, 26'd33, 26'd44};
  endtask

  initial begin
    rst_mul_n = 1'b0;
    repeat (3) @(posedge clk_mul);
    #1;
    chk("reset done", done, 0);
    chk("reset c_bus zero", (c_bus == '0), 1);
    chk("reset zo_bus zero", (zo_bus == '0), 1);
    chk("reset sat_flag", sat_flag, 0);
    @(negedge clk_mul) rst_mul_n = 1'b1;
    @(negedge clk_mul);
    chk("ready after reset", ready, 1);

    setup_t1();
    do_op("T1", 1'b1, 256, 1'b0, -1, -1);
    chk("T1 literal c[37]", elem(c_bus, 37), 3700);

    for (int n = 0; n < NEL; n++) begin a_v[n] = 16384; b_v[n] = 4096; end
    zi_bus = {26'h1234567, 26'h0abcdef, 26'd5, 26'h3ffffff};
    do_op("T2", 1'b1, 256, 1'b0, -1, -1);
    chk("T2 literal c[17]", elem(c_bus, 17), 32768);
    chk("T2 literal sat", sat_flag, 0);

    for (int n = 0; n < NEL; n++) begin
      a_v[n] = ((n % 16) / 4 == n % 4) ? -8192 : 0;
      b_v[n] = 24576;
    end
    zi_bus = {26'd1, 26'd2, 26'd3, 26'd4};
    do_op("T3", 1'b1, 256, 1'b1, -1, -1);
    chk("T3 literal c[5]", elem(c_bus, 5), -24576);
    chk("T3 literal zw[9]", elem(zw_bus, 9), 24576);
    chk("T3 literal zo[0]", longint'(zo_bus[W-1:0]), 4);

    for (int n = 0; n < NEL; n++) begin a_v[n] = 819200; b_v[n] = 819200; end
    do_op("T4", 1'b1, 256, 1'b0, -1, -1);
`ifdef ONE_UNIT_MUL3_SAT_EN
    chk("T4 literal c[40]", elem(c_bus, 40), 33554431);
    chk("T4 literal sat", sat_flag, 1);
`else
    chk("T4 literal c[40]", elem(c_bus, 40), -7864320);
    chk("T4 literal sat", sat_flag, 0);
`endif

    for (int n = 0; n < NEL; n++) begin a_v[n] = n; b_v[n] = 7 * n - 100; end
    do_op("T5 bypass", 1'b0, 0, 1'b0, -1, -1);
    chk("T5 literal c[63]", elem(c_bus, 63), 63);

    setup_t1();
    do_op("T5 start during MAC", 1'b1, 256, 1'b0, 50, -1);

    for (int n = 0; n < NEL; n++) begin a_v[n] = 8192 + n; b_v[n] = 3 * n; end
    do_op("T6 abort", 1'b1, 256, 1'b0, -1, 100);
    setup_t1();
    do_op("T6 rerun", 1'b1, 256, 1'b0, -1, -1);
    chk("T6 literal c[2]", elem(c_bus, 2), 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
